// File: rtl/divmod_recombine.sv
// divmod_recombine
//   Sequential inverse of a WIDTH-bit divide/modulo datapath. Accepts a
//   quotient, remainder and divisor and rebuilds the dividend
//   quot*div + rem with a shift-add multiplier. It also flags tuples that no
//   legal WIDTH-bit divide could have produced. The engine handles one
//   transaction at a time and uses valid/ready handshakes on both sides.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous, active-high reset
//     in_valid   operand tuple valid
//     in_ready   engine can accept a tuple (IDLE only, low while rst is high)
//     quot       quotient  [WIDTH-1:0]
//     rem        remainder [WIDTH-1:0]
//     div        divisor   [WIDTH-1:0]
//     out_valid  result valid (DONE only)
//     out_ready  consumer accepts result
//     dividend   quot*div + rem [2*WIDTH-1:0], registered, 0 unless out_valid
//     err        tuple inconsistent with a WIDTH-bit divide, registered
//
//   Timing
//     The tuple is accepted on edge N. The next WIDTH CALC edges each do one
//     shift-add step. The following edge registers the result and enters DONE,
//     so out_valid is high after edge N+WIDTH+1.
module divmod_recombine #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   quot,
  input  logic [WIDTH-1:0]   rem,
  input  logic [WIDTH-1:0]   div,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] dividend,
  output logic               err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               bad;
  logic               steps_done;

  // All WIDTH multiplier bits have been consumed. The next CALC edge
  // registers the result instead of stepping again.
  assign steps_done = (cnt == CW'(WIDTH));

  // State register
  // NOTE: Sequential state uses non-blocking assignments so that every
  // register samples pre-edge values. The reset is asynchronous, so the FSM
  // drops to IDLE as soon as rst rises, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  // NOTE: Each combinational output gets a default before the case. This
  // keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)             state_next = CALC;
      CALC:    if (steps_done)           state_next = DONE;
      DONE:    if (out_ready)            state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // Output logic
  // in_ready is gated by rst so that it reads 0 while the engine is held in
  // reset, even though the state already shows IDLE.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = ~rst;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, shift-add steps, result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      bad      <= 1'b0;
      dividend <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= {{WIDTH{1'b0}}, rem};
            mcand  <= {{WIDTH{1'b0}}, div};
            mplier <= quot;
            cnt    <= '0;
            // div==0 is covered by rem>=div. It is kept explicit for clarity.
            bad    <= (div == '0) || (rem >= div);
          end
        end
        CALC: begin
          if (!steps_done) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end else begin
            dividend <= acc;
            // Any legal WIDTH-bit divide gives a dividend that fits in WIDTH bits.
            err      <= bad || (|acc[2*WIDTH-1:WIDTH]);
          end
        end
        DONE: begin
          if (out_ready) begin
            dividend <= '0;
            err      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
